pattern_load_master: RTL and testbench

- Parametrised successor to the game's master-pattern loader: collects NUM_SLOTS secret shapes from the player/host before play starts.
- Each slot is write-once, and loads are accepted only in round 0.
- Adds per-request ack/error reporting with error codes, a synchronous clear, a FILL/FULL state machine and per-slot valid flags.
- Sits between the input/keypad front end and the round/compare logic, which reads `slots` once `all_loaded` is high.

---
 rtl/pattern_pkg.sv | 16 +
 rtl/pattern_load_master_rise_detect.sv | 19 +
 rtl/pattern_load_master.sv | 145 ++++++++++++++
 tb/tb_pattern_load_master.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_pkg.sv
// Shared types for the master-pattern loader: empty-shape code, loader state
// and rejection reason codes.
package pattern_pkg;

    localparam int EMPTY_SHAPE = 0;

    typedef enum {FILL, FULL} load_state_t;

    typedef enum logic [1:0] {
        ERR_OCCUPIED    = 2'd0,
        ERR_BAD_SHAPE   = 2'd1,
        ERR_WRONG_ROUND = 2'd2,
        ERR_BAD_SLOT    = 2'd3
    } load_err_t;

endpackage

// File: rtl/pattern_load_master_rise_detect.sv
// Single-bit rising-edge detector; the history bit resets high so a level
// already asserted when reset releases is not reported as an edge.
module rise_detect (
    input  logic CLOCK_50,
    input  logic reset_n,
    input  logic sig,
    output logic rise
);

    logic prev;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) prev <= 1'b1;
        else          prev <= sig;
    end

    assign rise = sig & ~prev;

endmodule

// File: rtl/pattern_load_master.sv
// Master-pattern loader: write-once shape slots filled in round 0, with a
// two-clock capture/commit pipeline and ack/err reporting.
// Build option AUTO_SLOT_EN: target slot is the lowest-index empty slot.
module pattern_load_master
    import pattern_pkg::*;
#(
    parameter  int NUM_SLOTS = 4,
    parameter  int SHAPE_W   = 3,
    parameter  int ROUND_W   = 4,
    localparam int SLOT_W    = $clog2(NUM_SLOTS)
) (
    input  logic                         CLOCK_50,
    input  logic                         reset_n,
    input  logic                         load_req,
    input  logic [SHAPE_W-1:0]           load_shape,
    input  logic [SLOT_W-1:0]            load_slot,
    input  logic [ROUND_W-1:0]           round_num,
    input  logic                         clear,
    output logic [NUM_SLOTS*SHAPE_W-1:0] slots,
    output logic [NUM_SLOTS-1:0]         slot_valid,
    output logic                         all_loaded,
    output logic                         load_ack,
    output logic                         load_err,
    output logic [1:0]                   err_code
);

    logic                         rise;
    logic                         pending;
    logic [SHAPE_W-1:0]           capShape;
    logic [SLOT_W-1:0]            capSlot;
    logic                         capRoundOk;
    logic [NUM_SLOTS*SHAPE_W-1:0] slotBank;
    logic [NUM_SLOTS-1:0]         slotValid;
    logic [NUM_SLOTS-1:0]         validAfter;
    logic                         loadAck;
    logic                         loadErr;
    load_err_t                    errCode;
    load_err_t                    errNext;
    logic                         accept;
    logic [SLOT_W-1:0]            target;
    logic                         slotOk;
    logic                         occupied;
    logic                         allLoaded;
    load_state_t                  state;
    load_state_t                  stateNext;

    rise_detect reqEdge (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (reset_n),
        .sig      (load_req),
        .rise     (rise)
    );

    // Target selection and rejection priority for the request being committed.
    always_comb begin
        target   = capSlot;
        slotOk   = 1'b1;
        occupied = 1'b0;
`ifdef AUTO_SLOT_EN
        occupied = 1'b1;
        for (int unsigned i = NUM_SLOTS; i > 0; i--) begin
            if (!slotValid[i-1]) begin
                target   = SLOT_W'(i - 1);
                occupied = 1'b0;
            end
        end
`else
        slotOk = int'(capSlot) < NUM_SLOTS;
        if (slotOk) occupied = slotValid[capSlot];
`endif
        accept  = 1'b0;
        errNext = ERR_OCCUPIED;
        if (pending) begin
            if (clear)                                errNext = ERR_OCCUPIED;
            else if (!slotOk)                         errNext = ERR_BAD_SLOT;
            else if (capShape == SHAPE_W'(EMPTY_SHAPE)) errNext = ERR_BAD_SHAPE;
            else if (!capRoundOk)                     errNext = ERR_WRONG_ROUND;
            else if (occupied || state == FULL)       errNext = ERR_OCCUPIED;
            else                                      accept  = 1'b1;
        end
        validAfter = slotValid;
        if (accept) validAfter[target] = 1'b1;
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            pending    <= 1'b0;
            capShape   <= '0;
            capSlot    <= '0;
            capRoundOk <= 1'b0;
            slotBank   <= '0;
            slotValid  <= '0;
            loadAck    <= 1'b0;
            loadErr    <= 1'b0;
            errCode    <= ERR_OCCUPIED;
        end else begin
            loadAck <= 1'b0;
            loadErr <= 1'b0;
            if (rise) begin
                pending    <= 1'b1;
                capShape   <= load_shape;
                capSlot    <= load_slot;
                capRoundOk <= (round_num == '0);
            end else if (pending) begin
                pending <= 1'b0;
            end
            if (pending) begin
                loadAck <= accept;
                loadErr <= ~accept;
                if (!accept) errCode <= errNext;
            end
            // accept is never set while clear is high, so clear always wins
            if (clear) begin
                slotBank  <= '0;
                slotValid <= '0;
            end else if (accept) begin
                slotBank[target*SHAPE_W +: SHAPE_W] <= capShape;
                slotValid[target]                   <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) state <= FILL;
        else          state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        if (clear)                                      stateNext = FILL;
        else if (state == FILL && accept && validAfter == '1) stateNext = FULL;
    end

    always_comb begin
        allLoaded = (state == FULL);
    end

    assign slots      = slotBank;
    assign slot_valid = slotValid;
    assign all_loaded = allLoaded;
    assign load_ack   = loadAck;
    assign load_err   = loadErr;
    assign err_code   = errCode;

endmodule

// File: tb/tb_pattern_load_master.sv
// Scoreboard bench for pattern_load_master with six slots, so out-of-range
// slot numbers are representable; honours AUTO_SLOT_EN when defined.
module tb_pattern_load_master;
    import pattern_pkg::*;

    localparam int NS  = 6;
    localparam int SW  = 3;
    localparam int RW  = 4;
    localparam int SLW = $clog2(NS);

    logic              CLOCK_50 = 1'b0;
    logic              reset_n;
    logic              load_req;
    logic [SW-1:0]     load_shape;
    logic [SLW-1:0]    load_slot;
    logic [RW-1:0]     round_num;
    logic              clear;
    logic [NS*SW-1:0]  slots;
    logic [NS-1:0]     slot_valid;
    logic              all_loaded;
    logic              load_ack;
    logic              load_err;
    logic [1:0]        err_code;

    pattern_load_master #(.NUM_SLOTS(NS), .SHAPE_W(SW), .ROUND_W(RW)) dut (
        .CLOCK_50   (CLOCK_50),
        .reset_n    (reset_n),
        .load_req   (load_req),
        .load_shape (load_shape),
        .load_slot  (load_slot),
        .round_num  (round_num),
        .clear      (clear),
        .slots      (slots),
        .slot_valid (slot_valid),
        .all_loaded (all_loaded),
        .load_ack   (load_ack),
        .load_err   (load_err),
        .err_code   (err_code)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic       isAck;
        logic [1:0] code;
        logic       full;
        int         due;
    } exp_t;

    exp_t          sbq[$];
    exp_t          mon;
    int            testsRun    = 0;
    int            testsFailed = 0;
    int            cyc         = 0;
    int            pulses      = 0;
    logic [SW-1:0] mSlots[NS];
    logic          mValid[NS];
    logic          mFull;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] want);
        testsRun++;
        if (got !== want) begin
            testsFailed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [NS*SW-1:0] packSlots();
        logic [NS*SW-1:0] v;
        v = '0;
        for (int i = 0; i < NS; i++) v[i*SW +: SW] = mSlots[i];
        return v;
    endfunction

    function automatic logic [NS-1:0] packValid();
        logic [NS-1:0] v;
        for (int i = 0; i < NS; i++) v[i] = mValid[i];
        return v;
    endfunction

    task automatic modelClear();
        for (int i = 0; i < NS; i++) begin
            mSlots[i] = '0;
            mValid[i] = 1'b0;
        end
        mFull = 1'b0;
    endtask

    task automatic checkBank(input string tag);
        checkVal({tag, "_slots"}, 32'(slots), 32'(packSlots()));
        checkVal({tag, "_valid"}, 32'(slot_valid), 32'(packValid()));
        checkVal({tag, "_all_loaded"}, 32'(all_loaded), 32'(mFull));
    endtask

    // One request: raise load_req, optionally pulse clear on the capture or
    // commit edge, and change round_num between capture and commit.
    task automatic doLoad(input int shape, input int slot, input int rnd,
                          input bit clrCap, input bit clrCommit, input int rndCommit);
        exp_t       e;
        int         t;
        bit         ok;
        logic [1:0] code;
        @(negedge CLOCK_50);
        load_req   = 1'b1;
        load_shape = SW'(shape);
        load_slot  = SLW'(slot);
        round_num  = RW'(rnd);
        clear      = clrCap;
        e.due      = cyc + 2;
        if (clrCap) modelClear();
        @(negedge CLOCK_50);
        load_req   = 1'b0;
        load_shape = SW'($urandom);
        load_slot  = SLW'($urandom);
        round_num  = RW'(rndCommit);
        clear      = clrCommit;
        ok   = 1'b0;
        code = 2'd0;
`ifdef AUTO_SLOT_EN
        t = -1;
        for (int i = NS - 1; i >= 0; i--) if (!mValid[i]) t = i;
        if (clrCommit)   code = 2'd0;
        else if (shape == 0) code = 2'd1;
        else if (rnd != 0)   code = 2'd2;
        else if (t < 0)      code = 2'd0;
        else                 ok = 1'b1;
`else
        t = slot;
        if (clrCommit)       code = 2'd0;
        else if (slot >= NS) code = 2'd3;
        else if (shape == 0) code = 2'd1;
        else if (rnd != 0)   code = 2'd2;
        else if (mValid[slot] || mFull) code = 2'd0;
        else                 ok = 1'b1;
`endif
        if (clrCommit) modelClear();
        if (ok) begin
            mSlots[t] = SW'(shape);
            mValid[t] = 1'b1;
            mFull     = 1'b1;
            for (int i = 0; i < NS; i++) if (!mValid[i]) mFull = 1'b0;
        end
        e.isAck = ok;
        e.code  = code;
        e.full  = mFull;
        sbq.push_back(e);
        @(negedge CLOCK_50);
        clear     = 1'b0;
        round_num = '0;
        @(negedge CLOCK_50);
        checkBank("after_load");
    endtask

    task automatic doClear();
        @(negedge CLOCK_50);
        clear = 1'b1;
        @(negedge CLOCK_50);
        clear = 1'b0;
        modelClear();
        checkBank("after_clear");
    endtask

    always @(negedge CLOCK_50) begin
        if (reset_n && (load_ack || load_err)) begin
            pulses++;
            if (sbq.size() == 0) begin
                checkVal("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                mon = sbq.pop_front();
                checkVal("ack", 32'(load_ack), 32'(mon.isAck));
                checkVal("err", 32'(load_err), 32'(!mon.isAck));
                if (!mon.isAck) checkVal("err_code", 32'(err_code), 32'(mon.code));
                checkVal("latency", 32'(cyc), 32'(mon.due));
                checkVal("all_loaded_at_pulse", 32'(all_loaded), 32'(mon.full));
            end
        end
    end

    initial begin
        reset_n    = 1'b0;
        load_req   = 1'b1;
        clear      = 1'b0;
        load_shape = '0;
        load_slot  = '0;
        round_num  = '0;
        modelClear();
        repeat (3) @(negedge CLOCK_50);
        checkVal("rst_slots", 32'(slots), 32'd0);
        checkVal("rst_valid", 32'(slot_valid), 32'd0);
        checkVal("rst_all_loaded", 32'(all_loaded), 32'd0);
        checkVal("rst_ack", 32'(load_ack), 32'd0);
        checkVal("rst_err", 32'(load_err), 32'd0);
        checkVal("rst_err_code", 32'(err_code), 32'd0);

        // load_req held high across reset release must not count as an edge
        reset_n = 1'b1;
        repeat (10) @(negedge CLOCK_50);
        checkVal("held_req_no_pulse", 32'(pulses), 32'd0);
        load_req = 1'b0;

        doLoad(5, 0, 0, 0, 0, 0);
        doLoad(3, 1, 0, 0, 0, 0);
        doLoad(7, 2, 0, 0, 0, 0);
        doLoad(1, 3, 0, 0, 0, 0);
        doLoad(2, 4, 0, 0, 0, 0);
        doLoad(4, 5, 0, 0, 0, 0);
        checkVal("fill_low4", 32'(slots[4*SW-1:0]), 32'h3dd);
        checkVal("fill_full", 32'(all_loaded), 32'd1);

        doLoad(2, 0, 0, 0, 1, 0);
        doLoad(6, 2, 0, 0, 0, 0);
        doLoad(6, 2, 0, 0, 0, 0);
        doLoad(0, 1, 0, 0, 0, 0);
        doLoad(5, 6, 0, 0, 0, 0);
        doLoad(5, 3, 2, 0, 0, 0);
        doLoad(3, 3, 0, 0, 0, 7);
        doLoad(4, 1, 0, 1, 0, 0);
        doLoad(5, 0, 0, 0, 1, 0);

`ifdef AUTO_SLOT_EN
        doClear();
        doLoad(2, 0, 0, 0, 0, 0);
        doLoad(4, 0, 0, 0, 0, 0);
        doClear();
        doLoad(3, 5, 0, 0, 0, 0);
        checkVal("auto_slot0", 32'(slots[SW-1:0]), 32'd3);
        for (int i = 1; i < NS; i++) doLoad(i, 0, 0, 0, 0, 0);
        doLoad(7, 0, 0, 0, 0, 0);
`endif

        for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge CLOCK_50);
        checkVal("scoreboard_drained", 32'(sbq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
